// File: rtl/audio_mix_sat_if.sv
// rtl/audio_mix_sat_if.sv - sample/control bundle between a mixer source and audio_mix_sat
// master drives samples, strobes, gains and div; slave returns the mixed sample.
interface audio_mix_sat_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FM_WIDTH   = 14,
  parameter int PSG_WIDTH  = 11,
  parameter int GAIN_WIDTH = 8,
  parameter int COUNT_BITS = 10
);
  logic [COUNT_BITS-1:0]        div;
  logic signed [FM_WIDTH-1:0]   fm_in;
  logic                         fm_stb;
  logic [PSG_WIDTH-1:0]         psg_in;
  logic                         psg_stb;
  logic [GAIN_WIDTH-1:0]        fm_gain;
  logic [GAIN_WIDTH-1:0]        psg_gain;
  logic                         mute;
  logic signed [DATA_WIDTH-1:0] out;
  logic                         out_stb;
  logic                         clip;

  modport master (
    output div, fm_in, fm_stb, psg_in, psg_stb, fm_gain, psg_gain, mute,
    input  out, out_stb, clip
  );

  modport slave (
    input  div, fm_in, fm_stb, psg_in, psg_stb, fm_gain, psg_gain, mute,
    output out, out_stb, clip
  );
endinterface

// File: rtl/audio_mix_sat.sv
// rtl/audio_mix_sat.sv - FM+PSG gain mixer with saturation, one shared multiplier, div-tick output
// Optional soft mute ramp (extra SCALE state, 4-cycle latency) when AUDIO_MIX_SOFT_MUTE_EN is defined.
module audio_mix_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FM_WIDTH   = 14,
  parameter int PSG_WIDTH  = 11,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_SCALE = 6,
  parameter int COUNT_BITS = 10
) (
  input logic             clk,
  input logic             reset,
  audio_mix_sat_if.slave  bus
);
  localparam int ACC_W  = DATA_WIDTH + GAIN_WIDTH + 2;
  localparam int FM_SH  = DATA_WIDTH - FM_WIDTH;
  localparam int PSG_SH = DATA_WIDTH - PSG_WIDTH;
  localparam logic [PSG_WIDTH-1:0]  PSG_MID = {1'b1, {(PSG_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL_FM, S_MUL_PSG, S_SUM, S_SCALE} state_t;

  state_t                       r_state;
  logic [COUNT_BITS-1:0]        r_count;
  logic signed [FM_WIDTH-1:0]   r_fm_hold, r_fm_snap;
  logic [PSG_WIDTH-1:0]         r_psg_hold, r_psg_snap;
  logic [GAIN_WIDTH-1:0]        r_fm_gain, r_psg_gain;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [DATA_WIDTH-1:0] r_out;
  logic                         r_out_stb, r_clip;

  logic [COUNT_BITS-1:0]        w_div_eff;
  logic                         w_tick;
  logic signed [DATA_WIDTH-1:0] w_fa, w_pa, w_mul_a, w_sat;
  logic [GAIN_WIDTH-1:0]        w_mul_g;
  logic signed [ACC_W-1:0]      w_prod, w_r;
  logic                         w_ovf;

  assign w_div_eff = (bus.div < COUNT_BITS'(4)) ? COUNT_BITS'(4) : bus.div;
  assign w_tick    = (r_count == w_div_eff - COUNT_BITS'(1));

  // Flipping the PSG MSB recentres the unipolar sample around its midpoint.
  assign w_fa    = {r_fm_snap, {FM_SH{1'b0}}};
  assign w_pa    = {~r_psg_snap[PSG_WIDTH-1], r_psg_snap[PSG_WIDTH-2:0], {PSG_SH{1'b0}}};
  assign w_mul_a = (r_state == S_MUL_FM) ? w_fa : w_pa;
  assign w_mul_g = (r_state == S_MUL_FM) ? r_fm_gain : r_psg_gain;
  assign w_prod  = ACC_W'(w_mul_a) * ACC_W'($signed({1'b0, w_mul_g}));

  assign w_r   = r_acc >>> GAIN_SCALE;
  assign w_ovf = (w_r[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){w_r[ACC_W-1]}});
  assign w_sat = w_ovf ? (w_r[ACC_W-1] ? OUT_MIN : OUT_MAX) : w_r[DATA_WIDTH-1:0];

`ifdef AUDIO_MIX_SOFT_MUTE_EN
  localparam int SC_W = DATA_WIDTH + 7;
  logic [5:0]                   r_att;
  logic signed [DATA_WIDTH-1:0] r_sat;
  logic                         r_sat_clip;
  logic [6:0]                   w_factor;
  logic signed [SC_W-1:0]       w_scaled;

  assign w_factor = 7'd32 - {1'b0, r_att};
  assign w_scaled = SC_W'(r_sat) * SC_W'($signed({1'b0, w_factor}));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_fm_hold  <= '0;
      r_fm_snap  <= '0;
      r_psg_hold <= PSG_MID;
      r_psg_snap <= PSG_MID;
      r_fm_gain  <= '0;
      r_psg_gain <= '0;
      r_acc      <= '0;
      r_out      <= '0;
      r_out_stb  <= 1'b0;
      r_clip     <= 1'b0;
`ifdef AUDIO_MIX_SOFT_MUTE_EN
      r_att      <= '0;
      r_sat      <= '0;
      r_sat_clip <= 1'b0;
`endif
    end else begin
      r_out_stb <= 1'b0;
      r_clip    <= 1'b0;
      r_count   <= w_tick ? '0 : r_count + COUNT_BITS'(1);
      if (bus.fm_stb)  r_fm_hold  <= bus.fm_in;
      if (bus.psg_stb) r_psg_hold <= bus.psg_in;
      // A strobe landing on the tick bypasses the hold register.
      if (w_tick) begin
        r_fm_snap  <= bus.fm_stb  ? bus.fm_in  : r_fm_hold;
        r_psg_snap <= bus.psg_stb ? bus.psg_in : r_psg_hold;
        r_fm_gain  <= bus.fm_gain;
        r_psg_gain <= bus.psg_gain;
`ifdef AUDIO_MIX_SOFT_MUTE_EN
        if (bus.mute && r_att != 6'd32)
          r_att <= r_att + 6'd1;
        else if (!bus.mute && r_att != 6'd0)
          r_att <= r_att - 6'd1;
`endif
      end
      case (r_state)
        S_IDLE:    if (w_tick) r_state <= S_MUL_FM;
        S_MUL_FM:  begin
          r_acc   <= w_prod;
          r_state <= S_MUL_PSG;
        end
        S_MUL_PSG: begin
          r_acc   <= r_acc + w_prod;
          r_state <= S_SUM;
        end
        S_SUM: begin
`ifdef AUDIO_MIX_SOFT_MUTE_EN
          r_sat      <= w_sat;
          r_sat_clip <= w_ovf;
          r_state    <= S_SCALE;
`else
          r_out     <= bus.mute ? '0 : w_sat;
          r_clip    <= bus.mute ? 1'b0 : w_ovf;
          r_out_stb <= 1'b1;
          r_state   <= S_IDLE;
`endif
        end
        S_SCALE: begin
`ifdef AUDIO_MIX_SOFT_MUTE_EN
          // With div_eff==4 the next tick coincides with this state.
          r_out     <= w_scaled[DATA_WIDTH+4:5];
          r_clip    <= r_sat_clip;
          r_out_stb <= 1'b1;
          r_state   <= w_tick ? S_MUL_FM : S_IDLE;
`else
          r_state   <= S_IDLE;
`endif
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out     = r_out;
  assign bus.out_stb = r_out_stb;
  assign bus.clip    = r_clip;
endmodule
